// File: rtl/mac_pkg.sv
// mac_pkg: shared widths, transmit arbiter state encoding and channel constants
package mac_pkg;
  localparam int CW = 11;
  localparam int DW = 8;
  typedef enum logic [1:0] {IDLE, OFFER, XFER, GAP} tx_arb_state_t;
  localparam logic [1:0] CH0 = 2'b01;
  localparam logic [1:0] CH1 = 2'b10;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way picker, round-robin or fixed ch0 priority, one-hot result
module rr_arb2
  import mac_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       mode,
  output logic [1:0] win
);
  // a tie goes to ch0 in fixed mode or when ch1 was served last
  always_comb win = &req ? ((mode || last) ? CH0 : CH1) : req[0] ? CH0 : req[1] ? CH1 : 2'b00;
endmodule

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: shares the GMII transmit path between two frame sources
module tx_frame_arbiter #(
  parameter int CW = mac_pkg::CW,
  parameter int DW = mac_pkg::DW,
  parameter int GAP = 12,
  parameter bit PRIO_MODE = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] req0_count,
  input  logic          req0_ready,
  output logic          req0_ack,
  input  logic [DW-1:0] req0_data,
  input  logic          req0_empty,
  output logic          req0_rd,
  input  logic [CW-1:0] req1_count,
  input  logic          req1_ready,
  output logic          req1_ack,
  input  logic [DW-1:0] req1_data,
  input  logic          req1_empty,
  output logic          req1_rd,
  output logic [CW-1:0] tx_count,
  output logic          tx_ready,
  input  logic          tx_ack,
  output logic [DW-1:0] tx_data,
  output logic          tx_empty,
  input  logic          tx_rd,
  output logic [1:0]    grant,
  output logic          busy
);
  import mac_pkg::tx_arb_state_t;
  import mac_pkg::IDLE;
  import mac_pkg::OFFER;
  import mac_pkg::XFER;
  localparam int GW = $clog2(GAP) > 0 ? $clog2(GAP) : 1;
  tx_arb_state_t state, state_nx;
  logic [1:0] win, ack;
  logic [CW-1:0] win_count, remaining;
  logic [GW-1:0] gap_cnt;
  logic rr_last, take, drop, accept, in_xfer, dec, last_byte, gap_done;
  rr_arb2 u_arb (.req({req1_ready, req0_ready}), .last(rr_last), .mode(PRIO_MODE), .win(win));
  assign {req1_ack, req0_ack} = ack;
  assign busy = state != IDLE;
  // next state plus zero-latency routing of the granted FIFO while transferring
  always_comb begin
    win_count = win[1] ? req1_count : req0_count;
    take = state == IDLE && |win;
    drop = take && win_count == '0;
    accept = state == OFFER && tx_ready && tx_ack;
    in_xfer = state == XFER;
    tx_data = in_xfer ? (grant[1] ? req1_data : req0_data) : '0;
    tx_empty = in_xfer ? (grant[1] ? req1_empty : req0_empty) : 1'b1;
    req0_rd = in_xfer && grant[0] && tx_rd;
    req1_rd = in_xfer && grant[1] && tx_rd;
    dec = in_xfer && tx_rd && !tx_empty && remaining != '0;
    last_byte = dec && remaining == CW'(1);
    gap_done = state == mac_pkg::GAP && gap_cnt == '0;
    state_nx = (take && !drop) ? OFFER : accept ? XFER : last_byte ? mac_pkg::GAP : gap_done ? IDLE : state;
  end
  // state register; reset abandons any frame in flight
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // grant, offer handshake, byte countdown and inter-frame gap
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant <= '0;
      tx_ready <= 1'b0;
      tx_count <= '0;
      ack <= '0;
      rr_last <= 1'b1;
      remaining <= '0;
      gap_cnt <= '0;
    end else begin
      ack <= '0;
      tx_ready <= state == OFFER && !accept;
      if (take && !drop) begin
        grant <= win;
        tx_count <= win_count;
      end
      if (drop) begin
        ack <= win;
        rr_last <= win[1];
      end
      if (accept) begin
        ack <= grant;
        remaining <= tx_count;
      end
      if (dec) remaining <= remaining - CW'(1);
      if (last_byte) begin
        gap_cnt <= GW'(GAP - 1);
        rr_last <= grant[1];
        grant <= '0;
      end
      if (state == mac_pkg::GAP && gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
    end
  end
endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: directed, table-driven and random checks against a frame-level model
module tb_tx_frame_arbiter;
  localparam int CW = mac_pkg::CW;
  localparam int DW = mac_pkg::DW;
  localparam int GAP = 12;
  typedef struct {
    int owner;
    bit offered;
    bit moving;
    int left;
    int cool;
    int last;
    int count;
    bit [1:0] ackp;
  } mdl_t;
  typedef struct {
    bit rd;
    bit e0;
    bit e1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [DW-1:0] xd;
    bit xe;
    bit xr0;
    bit xr1;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW-1:0] req0_count = '0, req1_count = '0;
  logic req0_ready = 1'b0, req1_ready = 1'b0, req0_empty = 1'b1, req1_empty = 1'b1;
  logic [DW-1:0] req0_data = '0, req1_data = '0;
  logic tx_ack = 1'b0, tx_rd = 1'b0;
  logic req0_ack, req0_rd, req1_ack, req1_rd, tx_ready, tx_empty, busy;
  logic [CW-1:0] tx_count;
  logic [DW-1:0] tx_data;
  logic [1:0] grant;
  logic f_req0_ack, f_req0_rd, f_req1_ack, f_req1_rd, f_tx_ready, f_tx_empty, f_busy;
  logic [CW-1:0] f_tx_count;
  logic [DW-1:0] f_tx_data;
  logic [1:0] f_grant;
  int total = 0, bad = 0;
  int n_ack0, n_ack1, n_rd0, n_rd1;
  bit chk_on = 1'b0, auto_drop = 1'b0, auto_ds = 1'b0;
  mdl_t m0, m1;
  vec_t tv[6];
  always #5 clk = ~clk;
  tx_frame_arbiter #(.GAP(GAP), .PRIO_MODE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_count(req0_count), .req0_ready(req0_ready), .req0_ack(req0_ack),
    .req0_data(req0_data), .req0_empty(req0_empty), .req0_rd(req0_rd),
    .req1_count(req1_count), .req1_ready(req1_ready), .req1_ack(req1_ack),
    .req1_data(req1_data), .req1_empty(req1_empty), .req1_rd(req1_rd),
    .tx_count(tx_count), .tx_ready(tx_ready), .tx_ack(tx_ack), .tx_data(tx_data),
    .tx_empty(tx_empty), .tx_rd(tx_rd), .grant(grant), .busy(busy)
  );
  tx_frame_arbiter #(.GAP(GAP), .PRIO_MODE(1'b1)) dut_fix (
    .clk(clk), .rst_n(rst_n),
    .req0_count(req0_count), .req0_ready(req0_ready), .req0_ack(f_req0_ack),
    .req0_data(req0_data), .req0_empty(req0_empty), .req0_rd(f_req0_rd),
    .req1_count(req1_count), .req1_ready(req1_ready), .req1_ack(f_req1_ack),
    .req1_data(req1_data), .req1_empty(req1_empty), .req1_rd(f_req1_rd),
    .tx_count(f_tx_count), .tx_ready(f_tx_ready), .tx_ack(tx_ack), .tx_data(f_tx_data),
    .tx_empty(f_tx_empty), .tx_rd(tx_rd), .grant(f_grant), .busy(f_busy)
  );
  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
    end
  endfunction
  function automatic mdl_t mreset();
    mdl_t r;
    r = '{owner: -1, offered: 1'b0, moving: 1'b0, left: 0, cool: 0, last: 1, count: 0, ackp: 2'b00};
    return r;
  endfunction
  // one clock of the frame-level behaviour: offer, transfer, cool-down, then pick
  function automatic mdl_t mstep(mdl_t m, bit prio);
    mdl_t n = m;
    bit [1:0] rdy;
    int pick, cnt;
    n.ackp = 2'b00;
    if (!rst_n) return mreset();
    if (m.moving) begin
      if (tx_rd && !(m.owner == 1 ? req1_empty : req0_empty)) n.left--;
      if (n.left == 0) begin
        n.moving = 1'b0;
        n.last = m.owner;
        n.owner = -1;
        n.cool = GAP;
      end
    end else if (m.owner >= 0) begin
      if (m.offered && tx_ack) begin
        n.offered = 1'b0;
        n.moving = 1'b1;
        n.left = m.count;
        n.ackp[m.owner] = 1'b1;
      end else n.offered = 1'b1;
    end else if (m.cool > 0) n.cool--;
    else begin
      rdy = {req1_ready, req0_ready};
      pick = rdy == 2'b11 ? (prio ? 0 : 1 - m.last) : rdy[0] ? 0 : rdy[1] ? 1 : -1;
      if (pick >= 0) begin
        cnt = pick == 1 ? int'(req1_count) : int'(req0_count);
        if (cnt == 0) begin
          n.ackp[pick] = 1'b1;
          n.last = pick;
        end else begin
          n.owner = pick;
          n.count = cnt;
        end
      end
    end
    return n;
  endfunction
  function automatic logic [27:0] expv(mdl_t m);
    logic [1:0] g;
    bit mv, o1;
    g = m.owner < 0 ? 2'b00 : m.owner == 0 ? 2'b01 : 2'b10;
    mv = m.moving;
    o1 = m.owner == 1;
    return {g, (m.owner >= 0 || m.cool > 0), m.offered, CW'(m.count), m.ackp[1], m.ackp[0],
            mv ? (o1 ? req1_data : req0_data) : {DW{1'b0}}, mv ? (o1 ? req1_empty : req0_empty) : 1'b1,
            mv && o1 && tx_rd, mv && !o1 && tx_rd};
  endfunction
  task automatic tick();
    @(negedge clk);
    if (chk_on) begin
      chk("cycle_rr", 32'({grant, busy, tx_ready, tx_count, req1_ack, req0_ack, tx_data, tx_empty, req1_rd, req0_rd}), 32'(expv(m0)));
      chk("cycle_fix", 32'({f_grant, f_busy, f_tx_ready, f_tx_count, f_req1_ack, f_req0_ack, f_tx_data, f_tx_empty, f_req1_rd, f_req0_rd}), 32'(expv(m1)));
    end
    n_ack0 += int'(req0_ack);
    n_ack1 += int'(req1_ack);
    n_rd0 += int'(req0_rd);
    n_rd1 += int'(req1_rd);
    if (auto_drop && req0_ack) req0_ready = 1'b0;
    if (auto_drop && req1_ack) req1_ready = 1'b0;
    if (auto_ds) tx_ack = tx_ready;
    @(posedge clk);
    m0 = mstep(m0, 1'b0);
    m1 = mstep(m1, 1'b1);
    #1;
  endtask
  task automatic clr();
    n_ack0 = 0;
    n_ack1 = 0;
    n_rd0 = 0;
    n_rd1 = 0;
  endtask
  task automatic rst();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask
  task automatic to_xfer(input int ch, input int cnt, input int dly, output int lat);
    auto_drop = 1'b1;
    req0_empty = 1'b0;
    req1_empty = 1'b0;
    tx_rd = 1'b0;
    if (ch == 0) begin
      req0_count = CW'(cnt);
      req0_ready = 1'b1;
    end else begin
      req1_count = CW'(cnt);
      req1_ready = 1'b1;
    end
    lat = 0;
    while (!tx_ready && lat < 20) begin
      tick();
      lat++;
    end
    repeat (dly) tick();
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
  endtask
  task automatic drain(output int n);
    req0_empty = 1'b0;
    req1_empty = 1'b0;
    tx_rd = 1'b1;
    n = 0;
    while (grant != 2'b00 && n < 2100) begin
      tick();
      n++;
    end
    tx_rd = 1'b0;
  endtask
  task automatic idle_wait(output int n);
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    int lat, n, ng;
    logic [1:0] pg, pf;
    logic [1:0] q0[$], qf[$];
    int exp_rr[3], exp_fx[3];
    bit e3[6];
    bit seen;
    tv[0] = '{1'b1, 1'b0, 1'b0, 8'h11, 8'h22, 8'h22, 1'b0, 1'b0, 1'b1};
    tv[1] = '{1'b0, 1'b1, 1'b0, 8'h33, 8'h44, 8'h44, 1'b0, 1'b0, 1'b0};
    tv[2] = '{1'b1, 1'b0, 1'b1, 8'h55, 8'h66, 8'h66, 1'b1, 1'b0, 1'b1};
    tv[3] = '{1'b1, 1'b1, 1'b1, 8'hAA, 8'hBB, 8'hBB, 1'b1, 1'b0, 1'b1};
    tv[4] = '{1'b0, 1'b0, 1'b1, 8'h01, 8'hFE, 8'hFE, 1'b1, 1'b0, 1'b0};
    tv[5] = '{1'b1, 1'b1, 1'b0, 8'h7F, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1};
    exp_rr = '{1, 2, 1};
    exp_fx = '{1, 1, 1};
    e3 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    m0 = mreset();
    m1 = mreset();
    clr();
    tick();
    tick();
    chk_on = 1'b1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_ready", 32'(tx_ready), 32'd0);
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_acks", 32'({req1_ack, req0_ack}), 32'd0);
    chk("rst_tx_empty", 32'(tx_empty), 32'd1);
    rst_n = 1'b1;
    tick();
    // single ch0 frame of 64 bytes, downstream acks after 3 offered cycles
    clr();
    to_xfer(0, 64, 3, lat);
    chk("t1_latency", 32'(lat), 32'd2);
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_tx_count", 32'(tx_count), 32'd64);
    drain(n);
    idle_wait(ng);
    chk("t1_bytes", 32'(n), 32'd64);
    chk("t1_rd0", 32'(n_rd0), 32'd64);
    chk("t1_ack0", 32'(n_ack0), 32'd1);
    chk("t1_ack1", 32'(n_ack1), 32'd0);
    chk("t1_gap", 32'(ng), 32'(GAP));
    chk("t1_busy", 32'(busy), 32'd0);
    // both channels held ready: round-robin alternates, fixed priority keeps ch0
    rst();
    req0_count = CW'(10);
    req1_count = CW'(10);
    req0_empty = 1'b0;
    req1_empty = 1'b0;
    req0_ready = 1'b1;
    req1_ready = 1'b1;
    auto_drop = 1'b0;
    auto_ds = 1'b1;
    tx_rd = 1'b1;
    pg = 2'b00;
    pf = 2'b00;
    n = 0;
    while (q0.size() < 3 && n < 300) begin
      tick();
      n++;
      if (grant != 2'b00 && pg == 2'b00) q0.push_back(grant);
      if (f_grant != 2'b00 && pf == 2'b00) qf.push_back(f_grant);
      pg = grant;
      pf = f_grant;
    end
    chk("t2_frames_rr", 32'(q0.size()), 32'd3);
    chk("t2_frames_fix", 32'(qf.size()), 32'd3);
    for (int i = 0; i < 3 && i < q0.size(); i++) chk("t2_rr_grant", 32'(q0[i]), 32'(exp_rr[i]));
    for (int i = 0; i < 3 && i < qf.size(); i++) chk("t2_fix_grant", 32'(qf[i]), 32'(exp_fx[i]));
    auto_ds = 1'b0;
    tx_ack = 1'b0;
    tx_rd = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rst();
    // 4-byte frame read with empty bubbles: only non-empty reads count
    clr();
    to_xfer(0, 4, 0, lat);
    for (int i = 0; i < 6; i++) begin
      req0_empty = e3[i];
      tx_rd = 1'b1;
      tick();
      if (i < 5) chk("t3_still_xfer", 32'(grant), 32'd1);
    end
    tx_rd = 1'b0;
    req0_empty = 1'b0;
    chk("t3_grant_released", 32'(grant), 32'd0);
    chk("t3_in_gap", 32'(busy), 32'd1);
    chk("t3_rd0", 32'(n_rd0), 32'd6);
    idle_wait(ng);
    // combinational routing while ch1 owns the path
    to_xfer(1, 40, 1, lat);
    foreach (tv[i]) begin
      tx_rd = tv[i].rd;
      req0_empty = tv[i].e0;
      req1_empty = tv[i].e1;
      req0_data = tv[i].d0;
      req1_data = tv[i].d1;
      #1;
      chk("tbl_data", 32'(tx_data), 32'(tv[i].xd));
      chk("tbl_empty", 32'(tx_empty), 32'(tv[i].xe));
      chk("tbl_rd0", 32'(req0_rd), 32'(tv[i].xr0));
      chk("tbl_rd1", 32'(req1_rd), 32'(tv[i].xr1));
      tick();
    end
    drain(n);
    chk("tbl_drain", 32'(n), 32'd38);
    idle_wait(ng);
    // zero-length frame on ch1 is acked and never offered
    clr();
    req1_count = '0;
    req1_ready = 1'b1;
    auto_drop = 1'b1;
    tick();
    chk("t4_ack1", 32'(req1_ack), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      tick();
      seen |= tx_ready | busy;
    end
    chk("t4_never_offered", 32'(seen), 32'd0);
    chk("t4_ack_count", 32'(n_ack1), 32'd1);
    // reset in the middle of a transfer, then a fresh frame
    to_xfer(0, 40, 0, lat);
    tx_rd = 1'b1;
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_tx_ready", 32'(tx_ready), 32'd0);
    chk("t5_rd", 32'({req1_rd, req0_rd}), 32'd0);
    rst_n = 1'b1;
    tx_rd = 1'b0;
    clr();
    tick();
    to_xfer(0, 3, 0, lat);
    chk("t5_fresh_grant", 32'(grant), 32'd1);
    drain(n);
    idle_wait(ng);
    chk("t5_fresh_bytes", 32'(n_rd0), 32'd3);
    chk("t5_fresh_ack", 32'(n_ack0), 32'd1);
    // stray acks and a requester that withdraws during the offer
    clr();
    tx_ack = 1'b1;
    tick();
    tick();
    chk("t6_idle_busy", 32'(busy), 32'd0);
    chk("t6_idle_ready", 32'(tx_ready), 32'd0);
    tx_ack = 1'b0;
    auto_drop = 1'b0;
    req0_count = CW'(5);
    req0_ready = 1'b1;
    tick();
    tick();
    req0_ready = 1'b0;
    tick();
    tick();
    chk("t6_offer_held", 32'(tx_ready), 32'd1);
    chk("t6_offer_grant", 32'(grant), 32'd1);
    chk("t6_offer_count", 32'(tx_count), 32'd5);
    tx_ack = 1'b1;
    tick();
    chk("t6_ack0", 32'(req0_ack), 32'd1);
    tick();
    tick();
    tx_ack = 1'b0;
    chk("t6_xfer_grant", 32'(grant), 32'd1);
    chk("t6_xfer_ready", 32'(tx_ready), 32'd0);
    chk("t6_single_ack", 32'(n_ack0), 32'd1);
    drain(n);
    chk("t6_bytes", 32'(n), 32'd5);
    idle_wait(ng);
    // random traffic, every cycle compared with the model
    rst();
    auto_drop = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (!req0_ready && $urandom_range(3) == 0) begin
        req0_count = CW'($urandom_range(6));
        req0_ready = 1'b1;
      end
      if (!req1_ready && $urandom_range(3) == 0) begin
        req1_count = CW'($urandom_range(6));
        req1_ready = 1'b1;
      end
      req0_data = DW'($urandom);
      req1_data = DW'($urandom);
      req0_empty = $urandom_range(2) == 0;
      req1_empty = $urandom_range(2) == 0;
      tx_ack = $urandom_range(1) == 1;
      tx_rd = $urandom_range(2) != 0;
      rst_n = $urandom_range(499) != 0;
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
